pointer_chase_multibank: RTL and testbench
==========================================

Name: pointer_chase_multibank

Overview:
- Parametrised successor to the single-bank pointer-read microbenchmark.
- Reads a run of entries from NUM_BANKS parallel CoRAM memory banks (SIMD_WIDTH lanes each), chasing a next-pointer word and optionally computing a checksum over all lanes.
- Reports results to the control thread over a CoRAM channel, and reports a 64-bit cycle count at finish.
- Memory and channel interfaces are ports; a thin wrapper instantiates CoramMemory1P per bank and one CoramChannel.

Parameters:
- SIMD_WIDTH, 4, lanes per bank word.
- LOG_SIMD_WIDTH, 2, log2(SIMD_WIDTH).
- W_D, 32, lane width.
- W_A, 12, bank address width.
- NUM_BANKS, 2, parallel banks (>=1).
- PTR_LANE, 0, lane of bank 0, address 0, that holds the next pointer.
- W_COMM_D, 32, channel data width (>= W_D).

Ports:
- CLK  in  1  clock
- RST  in  1  reset, synchronous, active-high
- comm_d  out  W_COMM_D  channel enqueue data
- comm_enq  out  1  enqueue pulse
- comm_full  in  1  channel full
- comm_q  in  W_COMM_D  channel dequeue data, valid the cycle after comm_deq
- comm_deq  out  1  dequeue pulse
- comm_empty  in  1  channel empty
- mem_addr  out  NUM_BANKS*W_A  per-bank address; all banks driven with the same value
- mem_q  in  NUM_BANKS*W_D*SIMD_WIDTH  per-bank read data, 1-cycle latency
- busy  out  1  high whenever state != IDLE

Behaviour:
- Reset: all outputs 0; state IDLE; cyclecount, checksum, next_ptr, read_size, mode all cleared.
- Pulses: comm_enq and comm_deq are single-cycle pulses, default 0 every cycle. Never enqueue while comm_full is high; never dequeue while comm_empty is high.
- Cycle counter: cyclecount (64 bit) holds 0 in IDLE and increments every cycle otherwise.
- IDLE: if !comm_empty, deq; go to START. START: latch mode = comm_q[0] (0 = pointer only, 1 = pointer + checksum); go to CMD_WAIT.
- CMD_WAIT: if !comm_empty, deq; go to CMD.
- CMD: if comm_q == 0, go to FIN_LO. Otherwise read_size = min(comm_q, 2^W_A), addr = 0, checksum = 0; go to READ.
- READ: issue addr each cycle; addr increments; on the last issued address (addr == read_size-1) go to DRAIN. A data-valid flag delayed one cycle marks returning data:
  - While the flag is set, checksum += sum of all NUM_BANKS*SIMD_WIDTH lanes, zero-extended, mod 2^W_COMM_D.
  - The data for address 0 sets next_ptr = bank0 lane PTR_LANE.
- DRAIN: one cycle to accumulate the final word; go to SEND_PTR.
- SEND_PTR: when !comm_full, enqueue next_ptr (zero-extended). Then go to SEND_SUM if mode = 1, else GAP.
- SEND_SUM: when !comm_full, enqueue checksum; go to GAP.
- GAP: one bubble cycle; go to CMD_WAIT.
- FIN_LO: when !comm_full, enqueue cyclecount[W_COMM_D-1:0]; go to FIN_HI.
- FIN_HI: when !comm_full, enqueue cyclecount[63:W_COMM_D] (0 if W_COMM_D >= 64); go to IDLE.
- Latency: read_size = N gives N+1 cycles from entering READ to SEND_PTR.
- Boundaries:
  - read_size = 1: single issue, straight to DRAIN.
  - read_size > 2^W_A: clamped to 2^W_A; addr never wraps.
  - Back-pressure: comm_full held stalls the SEND/FIN states indefinitely with no data change.
  - RST mid-operation: returns to IDLE immediately; no partial enqueue is completed.
- Memory: read-only. Bank write ports are tied off in the wrapper (WE = 0, D = 0).

Decomposition:
- Shared package pointer_chase_pkg: state encoding constants (IDLE, START, CMD_WAIT, CMD, READ, DRAIN, SEND_PTR, SEND_SUM, GAP, FIN_LO, FIN_HI) and MODE_PTR / MODE_SUM.
- One sub-module: lane_adder_tree. Sums NUM_BANKS*SIMD_WIDTH lanes combinationally, feeding the checksum register.

Test Plan:
- Reset then idle: comm_empty = 1 -> busy = 0, all outputs 0, no deq pulses, cyclecount held at 0.
- Mode 0, NUM_BANKS = 2, SIMD_WIDTH = 4; bank0 addr0 lane0 = 0x40; send start 0, size 8, then 0 -> enqueues 0x40, then cycle-count low and high words; exactly 8 distinct addresses issued (0..7).
- Mode 1, every lane of every bank = 1, size 16 -> enqueues next_ptr, then checksum 128 (16*2*4).
- Back-pressure: hold comm_full = 1 for 10 cycles at SEND_PTR -> no enq during hold; the value enqueued on release is unchanged.
- Size 0x2000 with W_A = 12 -> clamped; exactly 4096 reads; addr peaks at 0xFFF, no wrap.
- RST asserted in READ at addr 5 -> next cycle state IDLE, mem_addr = 0, no enqueue; a new start/size command then completes normally.

Source files
------------

// File: rtl/pointer_chase_pkg.sv
// Shared definitions for the multi-bank pointer-chase microbenchmark:
// controller state encoding and the command-mode bit meanings.
package pointer_chase_pkg;

    // Controller states, in rough order of a command's life cycle.
    typedef enum logic [3:0] {
        IDLE     = 4'd0,
        START    = 4'd1,
        CMD_WAIT = 4'd2,
        CMD      = 4'd3,
        READ     = 4'd4,
        DRAIN    = 4'd5,
        SEND_PTR = 4'd6,
        SEND_SUM = 4'd7,
        GAP      = 4'd8,
        FIN_LO   = 4'd9,
        FIN_HI   = 4'd10
    } state_e;

    // Mode word bit 0: report the pointer only, or the pointer and the checksum.
    localparam logic MODE_PTR = 1'b0;
    localparam logic MODE_SUM = 1'b1;

    // Width of the free-running run-time counter reported at finish.
    localparam int CYC_W = 64;

endpackage

// File: rtl/pointer_chase_multibank_lane_adder_tree.sv
// Combinational pairwise adder tree over every lane of every bank word.
// Lanes are zero-extended to W_SUM and the result wraps mod 2^W_SUM.
module lane_adder_tree #(
    parameter int NUM_LANES = 8,
    parameter int W_D       = 32,
    parameter int W_SUM     = 32
) (
    input  logic [NUM_LANES*W_D-1:0] lanes_i,
    output logic [W_SUM-1:0]         sum_o
);

    // Leaf count rounded up to a power of two; spare leaves contribute zero.
    localparam int LEAVES = 1 << $clog2(NUM_LANES);

    logic [W_SUM-1:0] acc [LEAVES];

    // Load the leaves, then fold pairs level by level down to acc[0].
    always_comb begin
        for (int i = 0; i < NUM_LANES; i++) begin
            acc[i] = W_SUM'(lanes_i[i*W_D +: W_D]);
        end
        for (int i = NUM_LANES; i < LEAVES; i++) begin
            acc[i] = '0;
        end
        for (int w = LEAVES / 2; w > 0; w = w / 2) begin
            for (int i = 0; i < w; i++) begin
                acc[i] = acc[2*i] + acc[2*i+1];
            end
        end
        sum_o = acc[0];
    end

endmodule

// File: rtl/pointer_chase_multibank.sv
// Multi-bank pointer-chase microbenchmark controller. Takes a mode word
// and a list of run sizes from the control channel, streams each run out
// of all banks in lock-step, captures the next pointer from address 0 and
// optionally checksums every lane, then reports results and a 64-bit
// run-time count over the same channel.
module pointer_chase_multibank
    import pointer_chase_pkg::*;
#(
    parameter int SIMD_WIDTH     = 4,
    parameter int LOG_SIMD_WIDTH = 2,
    parameter int W_D            = 32,
    parameter int W_A            = 12,
    parameter int NUM_BANKS      = 2,
    parameter int PTR_LANE       = 0,
    parameter int W_COMM_D       = 32
) (
    input  logic                                CLK,
    input  logic                                RST,
    output logic [W_COMM_D-1:0]                 comm_d,
    output logic                                comm_enq,
    input  logic                                comm_full,
    input  logic [W_COMM_D-1:0]                 comm_q,
    output logic                                comm_deq,
    input  logic                                comm_empty,
    output logic [NUM_BANKS*W_A-1:0]            mem_addr,
    input  logic [NUM_BANKS*W_D*SIMD_WIDTH-1:0] mem_q,
    output logic                                busy
);

    localparam int           LANES    = NUM_BANKS << LOG_SIMD_WIDTH;
    localparam logic [W_A:0] MAX_SIZE = {1'b1, {W_A{1'b0}}};
    localparam logic [W_A:0] SIZE_ONE = (W_A+1)'(1);
    localparam logic [W_A-1:0] ADDR_ONE = W_A'(1);

    state_e              state_q;
    logic                mode_q;
    logic [W_A-1:0]      addr_q;
    logic [W_A:0]        size_q;
    logic [W_A:0]        size_d;
    logic                vld_q;
    logic                first_q;
    logic [W_D-1:0]      ptr_q;
    logic [W_COMM_D-1:0] sum_q;
    logic [W_COMM_D-1:0] sum_d;
    logic [W_COMM_D-1:0] lane_sum;
    logic [CYC_W-1:0]    cyc_q;

    lane_adder_tree #(
        .NUM_LANES (LANES),
        .W_D       (W_D),
        .W_SUM     (W_COMM_D)
    ) u_tree (
        .lanes_i (mem_q),
        .sum_o   (lane_sum)
    );

    assign sum_d = sum_q + lane_sum;

    // Run size from the command word, clamped so the bank address never wraps.
    always_comb begin
        size_d = comm_q[W_A:0];
        if (comm_q > W_COMM_D'(MAX_SIZE)) begin
            size_d = MAX_SIZE;
        end
    end

    // Channel handshakes are decoded straight from the registered state so
    // the dequeued word is on comm_q in the very next state, and so a full or
    // empty flag is honoured in the same cycle it is seen. Reset suppresses
    // both so an interrupted transfer never half-completes.
    assign comm_deq = !RST && !comm_empty &&
                      (state_q == IDLE || state_q == CMD_WAIT);
    assign comm_enq = !RST && !comm_full &&
                      (state_q == SEND_PTR || state_q == SEND_SUM ||
                       state_q == FIN_LO   || state_q == FIN_HI);

    // Enqueue payload: whichever result the current send state reports.
    always_comb begin
        comm_d = '0;
        case (state_q)
            SEND_PTR: comm_d = W_COMM_D'(ptr_q);
            SEND_SUM: comm_d = sum_q;
            FIN_LO:   comm_d = W_COMM_D'(cyc_q);
            FIN_HI:   comm_d = W_COMM_D'(cyc_q >> W_COMM_D);
            default:  comm_d = '0;
        endcase
    end

    assign busy     = (state_q != IDLE);
    assign mem_addr = {NUM_BANKS{addr_q}};

    // Controller: command parsing, address issue, accumulate, report.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            mode_q  <= MODE_PTR;
            addr_q  <= '0;
            size_q  <= '0;
            vld_q   <= 1'b0;
            first_q <= 1'b0;
            ptr_q   <= '0;
            sum_q   <= '0;
            cyc_q   <= '0;
        end else begin
            // Read data returns one cycle after its address is issued.
            vld_q   <= (state_q == READ);
            first_q <= (state_q == READ) && (addr_q == '0);
            cyc_q   <= (state_q == IDLE) ? '0 : cyc_q + 64'd1;

            if (vld_q) begin
                sum_q <= sum_d;
                if (first_q) begin
                    ptr_q <= mem_q[PTR_LANE*W_D +: W_D];
                end
            end

            case (state_q)
                IDLE: begin
                    if (!comm_empty) state_q <= START;
                end
                START: begin
                    mode_q  <= comm_q[0];
                    state_q <= CMD_WAIT;
                end
                CMD_WAIT: begin
                    if (!comm_empty) state_q <= CMD;
                end
                CMD: begin
                    if (comm_q == '0) begin
                        state_q <= FIN_LO;
                    end else begin
                        size_q  <= size_d;
                        addr_q  <= '0;
                        sum_q   <= '0;
                        state_q <= READ;
                    end
                end
                READ: begin
                    if ({1'b0, addr_q} == size_q - SIZE_ONE) begin
                        state_q <= DRAIN;
                    end else begin
                        addr_q <= addr_q + ADDR_ONE;
                    end
                end
                DRAIN: begin
                    state_q <= SEND_PTR;
                end
                SEND_PTR: begin
                    if (!comm_full) state_q <= (mode_q == MODE_SUM) ? SEND_SUM : GAP;
                end
                SEND_SUM: begin
                    if (!comm_full) state_q <= GAP;
                end
                GAP: begin
                    state_q <= CMD_WAIT;
                end
                FIN_LO: begin
                    if (!comm_full) state_q <= FIN_HI;
                end
                FIN_HI: begin
                    if (!comm_full) state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pointer_chase_multibank.sv
// Randomised bench for pointer_chase_multibank: a channel and memory model
// driven cycle by cycle, with a scoreboard of expected reports computed
// from the command list and memory contents.
module tb_pointer_chase_multibank;

    localparam int NB    = 2;
    localparam int SW    = 4;
    localparam int WD    = 32;
    localparam int WA    = 12;
    localparam int WC    = 32;
    localparam int PL    = 0;
    localparam int DEPTH = 1 << WA;
    localparam int LN    = NB * SW;

    logic                 CLK = 1'b0;
    logic                 RST;
    logic [WC-1:0]        comm_d;
    logic                 comm_enq;
    logic                 comm_full;
    logic [WC-1:0]        comm_q;
    logic                 comm_deq;
    logic                 comm_empty;
    logic [NB*WA-1:0]     mem_addr;
    logic [NB*WD*SW-1:0]  mem_q;
    logic                 busy;

    pointer_chase_multibank #(
        .SIMD_WIDTH(SW), .LOG_SIMD_WIDTH(2), .W_D(WD), .W_A(WA),
        .NUM_BANKS(NB), .PTR_LANE(PL), .W_COMM_D(WC)
    ) dut (
        .CLK(CLK), .RST(RST), .comm_d(comm_d), .comm_enq(comm_enq),
        .comm_full(comm_full), .comm_q(comm_q), .comm_deq(comm_deq),
        .comm_empty(comm_empty), .mem_addr(mem_addr), .mem_q(mem_q),
        .busy(busy)
    );

    always #5 CLK = ~CLK;

    typedef struct { logic [31:0] w; int kind; } cword_t;  // kind 0 mode, 1 size, 2 end
    typedef struct { int kind; logic [31:0] v; } exp_t;    // kind 0 ptr, 1 sum, 2 lo, 3 hi

    cword_t            in_q[$];
    exp_t              exp_q[$];
    logic [NB*WD*SW-1:0] mem [DEPTH];

    int          n_chk = 0, n_fail = 0;
    int          cyc = 0;
    bit          rst_force = 1'b1;
    int          rst_at = -100, bp_start = -100;
    bit          rst_arm = 0, bp_arm = 0, rand_full = 0, rand_gap = 0;
    bit          rd_active = 0;
    int          rd_c = 0, rd_n = 0;
    bit          pend = 0;
    logic [31:0] pend_w = '0;
    logic [WA-1:0] last_addr = '0;
    logic [63:0] busy_cnt = '0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    function automatic int clampn(input logic [31:0] s);
        return (s > 32'(DEPTH)) ? DEPTH : int'(s);
    endfunction

    // Reference: pointer is word 0 lane PL; checksum is all lanes of the run.
    task automatic load(input bit mode, input logic [31:0] sz[$]);
        in_q.push_back('{32'(mode), 0});
        foreach (sz[k]) begin
            int n;
            logic [31:0] s;
            in_q.push_back('{sz[k], 1});
            n = clampn(sz[k]);
            s = '0;
            for (int a = 0; a < n; a++)
                for (int j = 0; j < LN; j++) s += mem[a][j*WD +: WD];
            exp_q.push_back('{0, mem[0][PL*WD +: WD]});
            if (mode) exp_q.push_back('{1, s});
        end
        in_q.push_back('{32'd0, 2});
        exp_q.push_back('{2, 32'd0});
        exp_q.push_back('{3, 32'd0});
    endtask

    task automatic fill_rand();
        for (int a = 0; a < DEPTH; a++)
            for (int j = 0; j < LN; j++) mem[a][j*WD +: WD] = $urandom;
    endtask

    task automatic monitor();
        logic [WA-1:0] ea;
        exp_t e;
        cword_t w;
        chk("enq_while_full", 64'(comm_enq & comm_full), 64'd0);
        chk("deq_while_empty", 64'(comm_deq & comm_empty), 64'd0);
        if (cyc == rst_at + 1) begin
            chk("rst_busy", 64'(busy), 64'd0);
            chk("rst_addr", 64'(mem_addr), 64'd0);
            chk("rst_enq", 64'(comm_enq), 64'd0);
        end
        if (rd_active && cyc >= rd_c + 2 && cyc < rd_c + 2 + rd_n) begin
            ea = WA'(cyc - rd_c - 2);
            chk("rd_addr", 64'(mem_addr), 64'({ea, ea}));
        end
        if (rd_active && cyc == rd_c + rd_n + 3) begin
            chk("ptr_latency", 64'(comm_enq), 64'(!comm_full));
            rd_active = 0;
        end
        if (comm_enq) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_enq", 64'(comm_d), 64'hDEAD_0000_0000);
            end else begin
                e = exp_q.pop_front();
                case (e.kind)
                    0: chk("next_ptr", 64'(comm_d), 64'(e.v));
                    1: chk("checksum", 64'(comm_d), 64'(e.v));
                    2: chk("cyc_lo", 64'(comm_d), 64'(busy_cnt[31:0]));
                    default: chk("cyc_hi", 64'(comm_d), 64'(busy_cnt[63:32]));
                endcase
            end
        end
        if (comm_deq && in_q.size() != 0) begin
            w = in_q.pop_front();
            pend = 1;
            pend_w = w.w;
            if (w.kind == 1) begin
                rd_active = 1;
                rd_c = cyc;
                rd_n = clampn(w.w);
                if (bp_arm) begin bp_start = cyc + rd_n + 3; bp_arm = 0; end
                if (rst_arm) begin rst_at = cyc + 7; rst_arm = 0; end
            end
        end
        busy_cnt = busy ? busy_cnt + 64'd1 : 64'd0;
        last_addr = mem_addr[WA-1:0];
    endtask

    // One clock: drive this cycle's inputs just after the edge, check mid-cycle.
    task automatic step();
        @(posedge CLK);
        #1;
        cyc++;
        RST = rst_force || (cyc == rst_at);
        if (cyc == rst_at) begin
            in_q.delete();
            exp_q.delete();
            pend = 0;
            rd_active = 0;
        end
        if (pend) begin comm_q = pend_w; pend = 0; end
        mem_q = mem[last_addr];
        comm_empty = (in_q.size() == 0) || (rand_gap && $urandom_range(3) == 0);
        comm_full = (cyc >= bp_start && cyc < bp_start + 10) ||
                    (rand_full && $urandom_range(3) == 0);
        @(negedge CLK);
        monitor();
    endtask

    task automatic run(input int max_cyc);
        int k;
        k = 0;
        do begin
            step();
            k++;
        end while (!(in_q.size() == 0 && exp_q.size() == 0 && !busy && !pend) && k < max_cyc);
        if (k >= max_cyc) chk("timeout", 64'(exp_q.size() + in_q.size()), 64'd0);
        step();
        step();
    endtask

    initial begin
        logic [31:0] sz[$];
        RST = 1'b1; comm_q = '0; mem_q = '0; comm_full = 1'b0; comm_empty = 1'b1;
        for (int a = 0; a < DEPTH; a++) mem[a] = '0;

        // Reset, then idle with an empty channel.
        repeat (3) step();
        chk("rst_busy0", 64'(busy), 64'd0);
        chk("rst_comm_d", 64'(comm_d), 64'd0);
        chk("rst_mem_addr", 64'(mem_addr), 64'd0);
        rst_force = 1'b0;
        repeat (10) begin
            step();
            chk("idle_busy", 64'(busy), 64'd0);
            chk("idle_deq", 64'(comm_deq), 64'd0);
            chk("idle_enq", 64'(comm_enq), 64'd0);
        end

        // Mode 0, pointer 0x40, run of 8.
        fill_rand();
        mem[0][PL*WD +: WD] = 32'h40;
        sz = '{32'd8};
        load(1'b0, sz);
        run(200);

        // Mode 1, every lane 1, run of 16: checksum 128.
        for (int a = 0; a < DEPTH; a++) mem[a] = {LN{32'd1}};
        sz = '{32'd16};
        load(1'b1, sz);
        run(200);

        // Random sessions with random channel stalls.
        rand_full = 1; rand_gap = 1;
        for (int t = 0; t < 6; t++) begin
            fill_rand();
            sz.delete();
            for (int k = 0; k < int'($urandom_range(3)); k++) begin
                case ($urandom_range(2))
                    0: sz.push_back(32'd1);
                    1: sz.push_back(32'd2);
                    default: sz.push_back(32'($urandom_range(40, 3)));
                endcase
            end
            load(1'($urandom_range(1)), sz);
            run(1000);
        end

        // Back-pressure held for 10 cycles right at SEND_PTR.
        rand_full = 0; rand_gap = 0;
        fill_rand();
        bp_arm = 1;
        sz = '{32'd12};
        load(1'b1, sz);
        run(300);

        // Oversized run is clamped to the full bank depth.
        rand_full = 1;
        fill_rand();
        sz = '{32'h2000};
        load(1'b1, sz);
        run(6000);

        // Reset in the middle of a read, then a fresh command list.
        rand_full = 0;
        rst_arm = 1;
        sz = '{32'd20};
        load(1'b1, sz);
        run(300);
        fill_rand();
        sz = '{32'd10, 32'd3};
        load(1'b1, sz);
        run(300);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
